// File: rtl/lse_lut_loader.sv
// lse_lut_loader: sequential writer for the log-sum-exp correction LUT.
// Fills the table either from a valid/ready entry stream (followed by a
// checksum check) or by generating the default linear table (entry i = i).
// The table register array is exposed directly for lse_add's combinational
// reads; a registered debug read port is provided alongside.
module lse_lut_loader #(
    parameter int LUT_SIZE      = 1024,
    parameter int LUT_PRECISION = 10,
    parameter int ADDR_W        = 10
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    load_start,
    input  logic                                    gen_start,
    input  logic [15:0]                             expected_checksum,
    input  logic                                    wr_valid,
    input  logic [LUT_PRECISION-1:0]                wr_data,
    output logic                                    wr_ready,
    output logic [LUT_SIZE-1:0][LUT_PRECISION-1:0]  lut_table,
    output logic                                    lut_valid,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    error,
    output logic [15:0]                             checksum,
    input  logic [ADDR_W-1:0]                       rd_addr,
    output logic [LUT_PRECISION-1:0]                rd_data
);

    // Width of the internal write index; the debug address may be wider.
    localparam int IDX_W = (LUT_SIZE > 1) ? $clog2(LUT_SIZE) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LUT_SIZE - 1);
    localparam logic [ADDR_W:0]   SIZE_EXT = (ADDR_W + 1)'(LUT_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic [15:0]              exp_sum;
    logic [LUT_PRECISION-1:0] fill_val;
    logic                     accept;

    // Default table entry is its own index, truncated/extended to entry width.
    assign fill_val = LUT_PRECISION'(idx);
    // wr_ready is only ever high in LOAD, so this is a stream handshake.
    assign accept   = wr_valid && wr_ready;

    // Loader FSM: owns the table, the running checksum and all status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            exp_sum   <= '0;
            wr_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            lut_valid <= 1'b0;
            checksum  <= '0;
            lut_table <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // load_start takes priority when both starts arrive together.
                    if (load_start) begin
                        state     <= S_LOAD;
                        idx       <= '0;
                        checksum  <= '0;
                        lut_valid <= 1'b0;
                        error     <= 1'b0;
                        exp_sum   <= expected_checksum;
                        wr_ready  <= 1'b1;
                        busy      <= 1'b1;
                    end else if (gen_start) begin
                        state     <= S_FILL;
                        idx       <= '0;
                        checksum  <= '0;
                        lut_valid <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        lut_table[idx] <= wr_data;
                        checksum       <= checksum + 16'(wr_data);
                        if (idx == LAST_IDX) begin
                            // Index parks on the last entry rather than wrapping.
                            state    <= S_CHECK;
                            wr_ready <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    lut_table[idx] <= fill_val;
                    checksum       <= checksum + 16'(fill_val);
                    if (idx == LAST_IDX) begin
                        // Generated table is trusted by construction.
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        lut_valid <= 1'b1;
                        error     <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_CHECK: begin
                    state     <= S_DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    error     <= (checksum != exp_sum);
                    lut_valid <= (checksum == exp_sum);
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    wr_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Debug read: one-cycle latency, sees the table as of the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < SIZE_EXT) begin
            rd_data <= lut_table[rd_addr[IDX_W-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_lse_lut_loader.sv
// Self-checking bench for lse_lut_loader: reset, default fill, stream loads
// (clean, gapped, contention, mismatch) and reset in the middle of a load.
module tb_lse_lut_loader;

    localparam int LUT_SIZE      = 1024;
    localparam int LUT_PRECISION = 10;
    localparam int ADDR_W        = 10;

    logic                                   clk = 1'b0;
    logic                                   rst;
    logic                                   load_start;
    logic                                   gen_start;
    logic [15:0]                            expected_checksum;
    logic                                   wr_valid;
    logic [LUT_PRECISION-1:0]               wr_data;
    logic                                   wr_ready;
    logic [LUT_SIZE-1:0][LUT_PRECISION-1:0] lut_table;
    logic                                   lut_valid;
    logic                                   busy;
    logic                                   done;
    logic                                   error;
    logic [15:0]                            checksum;
    logic [ADDR_W-1:0]                      rd_addr;
    logic [LUT_PRECISION-1:0]               rd_data;

    always #5 clk = ~clk;

    lse_lut_loader #(
        .LUT_SIZE(LUT_SIZE), .LUT_PRECISION(LUT_PRECISION), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .gen_start(gen_start),
        .expected_checksum(expected_checksum), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_ready(wr_ready), .lut_table(lut_table),
        .lut_valid(lut_valid), .busy(busy), .done(done), .error(error),
        .checksum(checksum), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [LUT_PRECISION-1:0] model [LUT_SIZE];
    logic [LUT_PRECISION-1:0] sb_q [$];

    typedef struct {
        string tag;
        int    pat;        // 0: all ones, 1: scrambled values
        int    adj;        // offset added to the true sum for expected_checksum
        int    gap_after;  // entry index before which wr_valid drops (-1: none)
        int    gap_len;
        bit    both;       // raise gen_start together with load_start
        int    poke_cyc;   // cycle at which gen_start is pulsed mid-load (-1: none)
        int    exp_done;   // cycle of the done pulse, start edge = cycle 0
    } ld_vec_t;

    typedef struct {
        int addr;
        int exp;
    } rd_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LUT_PRECISION-1:0] pat_val(input int pat, input int e);
        if (pat == 0) return 10'd1;
        return 10'((e * 37 + 11) & 1023);
    endfunction

    // Scoreboard read: push the expectation when the address is driven,
    // pop and compare once the registered read data appears.
    task automatic rd_check(input string name, input int addr, input logic [LUT_PRECISION-1:0] exp);
        logic [LUT_PRECISION-1:0] e;
        rd_addr = ADDR_W'(addr);
        sb_q.push_back(exp);
        tick();
        e = sb_q.pop_front();
        chk(name, 32'(rd_data), 32'(e));
    endtask

    task automatic wait_done(input int budget, inout int cyc);
        while (done !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_fill(input string tag);
        int cyc;
        gen_start = 1'b1;
        tick();
        gen_start = 1'b0;
        cyc = 1;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_err_clr"}, 32'(error), 32'd0);
        chk({tag, "_lv_clr"}, 32'(lut_valid), 32'd0);
        wait_done(1100, cyc);
        chk({tag, "_done_cyc"}, 32'(cyc), 32'd1025);
        chk({tag, "_lut_valid"}, 32'(lut_valid), 32'd1);
        chk({tag, "_checksum"}, 32'(checksum), 32'hFE00);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        for (int i = 0; i < LUT_SIZE; i++) model[i] = 10'(i);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic do_load(input ld_vec_t v);
        int          cyc;
        logic [15:0] sum;
        sum = '0;
        for (int e = 0; e < LUT_SIZE; e++) sum = sum + 16'(pat_val(v.pat, e));
        expected_checksum = sum + 16'(v.adj);
        load_start = 1'b1;
        gen_start  = v.both;
        tick();
        load_start = 1'b0;
        gen_start  = 1'b0;
        cyc = 1;
        chk({v.tag, "_ready"}, 32'(wr_ready), 32'd1);
        chk({v.tag, "_lv_low"}, 32'(lut_valid), 32'd0);
        for (int e = 0; e < LUT_SIZE; e++) begin
            if (e == v.gap_after && v.gap_len > 0) begin
                wr_valid = 1'b0;
                repeat (v.gap_len) begin
                    tick();
                    cyc++;
                end
            end
            wr_valid  = 1'b1;
            wr_data   = pat_val(v.pat, e);
            gen_start = (cyc == v.poke_cyc);
            tick();
            cyc++;
            model[e] = pat_val(v.pat, e);
        end
        wr_valid  = 1'b0;
        gen_start = 1'b0;
        chk({v.tag, "_check_ready"}, 32'(wr_ready), 32'd0);
        chk({v.tag, "_check_busy"}, 32'(busy), 32'd1);
        wait_done(v.exp_done + 20, cyc);
        chk({v.tag, "_done_cyc"}, 32'(cyc), 32'(v.exp_done));
        chk({v.tag, "_error"}, 32'(error), 32'(v.adj != 0));
        chk({v.tag, "_lut_valid"}, 32'(lut_valid), 32'(v.adj == 0));
        chk({v.tag, "_checksum"}, 32'(checksum), 32'(sum));
        chk({v.tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({v.tag, "_tbl_last"}, 32'(lut_table[LUT_SIZE-1]), 32'(pat_val(v.pat, LUT_SIZE-1)));
        tick();
        chk({v.tag, "_done_pulse"}, 32'(done), 32'd0);
        rd_check({v.tag, "_rd0"}, 0, model[0]);
        rd_check({v.tag, "_rd100"}, 100, model[100]);
        rd_check({v.tag, "_rd1023"}, 1023, model[1023]);
    endtask

    ld_vec_t ld_vecs [4];
    rd_vec_t fill_rd [5];

    initial begin
        int nz;

        ld_vecs[0] = '{tag: "load_clean",    pat: 0, adj: 0, gap_after: 100, gap_len: 3, both: 1'b0, poke_cyc: -1, exp_done: 1029};
        ld_vecs[1] = '{tag: "load_scramble", pat: 1, adj: 0, gap_after: -1,  gap_len: 0, both: 1'b0, poke_cyc: -1, exp_done: 1026};
        ld_vecs[2] = '{tag: "load_contend",  pat: 0, adj: 0, gap_after: -1,  gap_len: 0, both: 1'b1, poke_cyc: 50, exp_done: 1026};
        ld_vecs[3] = '{tag: "load_mismatch", pat: 0, adj: 1, gap_after: 100, gap_len: 3, both: 1'b0, poke_cyc: -1, exp_done: 1029};

        fill_rd[0] = '{addr: 700,  exp: 700};
        fill_rd[1] = '{addr: 0,    exp: 0};
        fill_rd[2] = '{addr: 1023, exp: 1023};
        fill_rd[3] = '{addr: 5,    exp: 5};
        fill_rd[4] = '{addr: 512,  exp: 512};

        // Reset with wr_valid held high to show IDLE never accepts.
        rst = 1'b1; load_start = 1'b0; gen_start = 1'b0;
        expected_checksum = '0; wr_valid = 1'b1; wr_data = '1; rd_addr = '0;
        for (int i = 0; i < LUT_SIZE; i++) model[i] = '0;
        repeat (2) tick();
        rst = 1'b0;
        rd_addr = ADDR_W'(5);
        tick();
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_lut_valid", 32'(lut_valid), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        nz = 0;
        for (int i = 0; i < LUT_SIZE; i++) if (lut_table[i] != '0) nz++;
        chk("rst_table_nonzero", 32'(nz), 32'd0);
        tick();
        chk("idle_wr_ready", 32'(wr_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        wr_valid = 1'b0;

        // Default linear fill, then table-driven debug reads.
        do_fill("fill");
        foreach (fill_rd[k]) rd_check($sformatf("fill_rd%0d", fill_rd[k].addr), fill_rd[k].addr, 10'(fill_rd[k].exp));

        // Stream load scenarios.
        foreach (ld_vecs[k]) do_load(ld_vecs[k]);

        // A fill after the mismatching load clears error.
        chk("pre_fill_error", 32'(error), 32'd1);
        do_fill("fill_clr");

        // Reset after 300 accepted entries.
        expected_checksum = 16'h0400;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int e = 0; e < 300; e++) begin
            wr_valid = 1'b1;
            wr_data  = 10'd1;
            tick();
        end
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_checksum", 32'(checksum), 32'd300);
        rst = 1'b1;
        wr_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_lut_valid", 32'(lut_valid), 32'd0);
        chk("abort_checksum", 32'(checksum), 32'd0);
        chk("abort_wr_ready", 32'(wr_ready), 32'd0);
        nz = 0;
        for (int i = 0; i < 300; i++) if (lut_table[i] != '0) nz++;
        chk("abort_low300_nonzero", 32'(nz), 32'd0);
        chk("abort_tbl700", 32'(lut_table[700]), 32'd0);
        for (int i = 0; i < LUT_SIZE; i++) model[i] = '0;
        rd_check("abort_rd700", 700, model[700]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
